// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the AXI read-channel arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic ARB_M_ICACHE = 1'b0;
  localparam logic ARB_M_DCACHE = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - 2-way combinational picker; AXI_RD_ARB_RR_EN selects round-robin ties
module arb_pick
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx
);

`ifdef AXI_RD_ARB_RR_EN
  // On a tie the master not granted last time wins.
  always_comb begin
    if (req == 2'b11)
      gnt_idx = ~last;
    else if (req[1])
      gnt_idx = ARB_M_DCACHE;
    else
      gnt_idx = ARB_M_ICACHE;
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt_idx = req[1] ? ARB_M_DCACHE : ARB_M_ICACHE;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI read channel between ICache and DCache; AXI_RD_ARB_RR_EN enables round-robin
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADDR_W-1:0]   m_araddr,
  input  logic [2*LEN_W-1:0]    m_arlen,
  input  logic [5:0]            m_arsize,
  input  logic [1:0]            m_arvalid,
  output logic [1:0]            m_arready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic [1:0]            m_rvalid,
  input  logic [1:0]            m_rready,
  output logic [3:0]            s_arid,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [LEN_W-1:0]      s_arlen,
  output logic [2:0]            s_arsize,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  busy,
  output logic                  len_err
);

  arb_state_t       state_q, state_d;
  logic             grant_q;
  logic             pick_idx;
  logic             last_gnt;
  logic [LEN_W-1:0] len_q, beat_q;
  logic             len_err_q;
  logic             ar_hs;
  logic             beat;
  logic             err_now;
  logic             grant_load;

  assign grant_load = (state_q == IDLE) && (|m_arvalid);

  arb_pick u_pick (
    .req     (m_arvalid),
    .last    (last_gnt),
    .gnt_idx (pick_idx)
  );

`ifdef AXI_RD_ARB_RR_EN
  logic last_q;

  // Resets to DCache so ICache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= ARB_M_DCACHE;
    else if (grant_load)
      last_q <= pick_idx;
  end

  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b0;
`endif

  assign s_arid   = {3'b000, grant_q};
  assign s_araddr = grant_q ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
  assign s_arlen  = grant_q ? m_arlen[2*LEN_W-1:LEN_W]    : m_arlen[LEN_W-1:0];
  assign s_arsize = grant_q ? m_arsize[5:3]               : m_arsize[2:0];

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  always_comb begin
    state_d   = state_q;
    s_arvalid = 1'b0;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    s_rready  = 1'b0;
    ar_hs     = 1'b0;
    beat      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_arvalid)
          state_d = ADDR;
      end
      ADDR: begin
        s_arvalid          = m_arvalid[grant_q];
        m_arready[grant_q] = s_arready;
        ar_hs              = m_arvalid[grant_q] & s_arready;
        if (ar_hs)
          state_d = DATA;
        else if (!m_arvalid[grant_q])
          state_d = IDLE;
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
        beat              = s_rvalid & m_rready[grant_q];
        if (beat && s_rlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rlast early, or a non-last beat already at the announced length.
  assign err_now = beat & ((s_rlast & (beat_q != len_q)) | (~s_rlast & (beat_q == len_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= ARB_M_ICACHE;
      len_q     <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_load)
        grant_q <= pick_idx;
      if (ar_hs) begin
        len_q  <= s_arlen;
        beat_q <= '0;
      end else if (beat) begin
        beat_q <= beat_q + LEN_W'(1);
      end
      if (err_now)
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q | err_now;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [1:0]  m_arvalid;
  logic [1:0]  m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic        busy;
  logic        len_err;

  axi_rd_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .busy      (busy),
    .len_err   (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [1:0] req;
    int         first;
    int         second;
    logic [7:0] len;
  } vec_t;

  ar_t         ar_q[$];
  logic [31:0] rd_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [31:0] addr, input logic [7:0] len);
    m_araddr[id*32 +: 32] = addr;
    m_arlen[id*8 +: 8]    = len;
    m_arsize[id*3 +: 3]   = 3'd2;
    m_arvalid[id]         = 1'b1;
  endtask

  task automatic push_ar(input int id, input logic [31:0] addr, input logic [7:0] len);
    ar_t e;
    e.id   = 4'(id);
    e.addr = addr;
    e.len  = len;
    ar_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_arvalid"}, s_arvalid, 0);
    chk({tag, "_m_arready"}, m_arready, 0);
    chk({tag, "_m_rvalid"}, m_rvalid, 0);
    chk({tag, "_s_rready"}, s_rready, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_s_arid"}, s_arid, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_arvalid = 2'b00; m_rready = 2'b00;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    tick();
    tick();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  // Waits for the address phase, optionally stalls it, then accepts it
  // and checks it against the next expected request.
  task automatic serve_ar(input int hold);
    ar_t e;
    int  n;
    n = 0;
    while (s_arvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", s_arvalid, 1);
    if (ar_q.size() == 0) begin
      chk("ar_queue_empty", 1, 0);
      return;
    end
    e = ar_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("ar_hold_valid", s_arvalid, 1);
      chk("ar_hold_addr", s_araddr, e.addr);
      chk("ar_hold_id", s_arid, e.id);
      chk("ar_hold_busy", busy, 1);
      chk("ar_hold_m_arready", m_arready, 0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    chk("ar_id", s_arid, e.id);
    chk("ar_addr", s_araddr, e.addr);
    chk("ar_len", s_arlen, e.len);
    chk("ar_size", s_arsize, 2);
    chk("ar_m_arready", m_arready, 2'b01 << e.id[0]);
    tick();
    s_arready = 1'b0;
    m_arvalid[e.id[0]] = 1'b0;
  endtask

  // Drives nbeats beats with rlast on the final one; tracks the expected
  // sticky length error from the announced arlen.
  task automatic serve_r(input int id, input int len, input int nbeats, input bit err_in);
    logic [31:0] d;
    bit          e;
    e = err_in;
    for (int b = 0; b < nbeats; b++) begin
      d        = $urandom;
      s_rdata  = d;
      s_rresp  = 2'b00;
      s_rlast  = (b == nbeats - 1);
      s_rvalid = 1'b1;
      rd_q.push_back(d);
      if (b == 1) begin
        m_rready = 2'b00;
        #1;
        chk("r_stall_s_rready", s_rready, 0);
        chk("r_stall_m_rvalid", m_rvalid, 2'b01 << id);
        tick();
      end
      m_rready = 2'b11;
      #1;
      if (b == nbeats - 1) e = e | (b != len);
      else                 e = e | (b == len);
      chk("r_valid", m_rvalid, 2'b01 << id);
      chk("r_s_rready", s_rready, 1);
      chk("r_data", m_rdata, rd_q.pop_front());
      chk("r_last", m_rlast, (b == nbeats - 1));
      chk("r_len_err", len_err, e);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = 2'b00;
    #1;
    chk("r_busy_after_last", busy, 0);
    chk("r_gap_s_arvalid", s_arvalid, 0);
    chk("r_len_err_after", len_err, e);
  endtask

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef AXI_RD_ARB_RR_EN
    vecs[0] = '{req: 2'b11, first: 0, second: 1,  len: 8'd2};
    vecs[1] = '{req: 2'b11, first: 0, second: 1,  len: 8'd1};
`else
    vecs[0] = '{req: 2'b11, first: 1, second: 0,  len: 8'd2};
    vecs[1] = '{req: 2'b11, first: 1, second: 0,  len: 8'd1};
`endif
    vecs[2] = '{req: 2'b01, first: 0, second: -1, len: 8'd0};
    vecs[3] = '{req: 2'b10, first: 1, second: -1, len: 8'd3};

    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arvalid = '0; m_rready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    apply_reset();

    // ICache alone, one-cycle request latency, four beats
    set_req(0, 32'hBFC0_0000, 8'd3);
    push_ar(0, 32'hBFC0_0000, 8'd3);
    #1;
    chk("lat_idle_s_arvalid", s_arvalid, 0);
    tick();
    #1;
    chk("lat_s_arvalid", s_arvalid, 1);
    chk("lat_s_arid", s_arid, 0);
    serve_ar(0);
    serve_r(0, 3, 4, 1'b0);

    // Arbitration table
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      for (int m = 0; m < 2; m++)
        if (vecs[r].req[m])
          set_req(m, 32'h1000_0000 * (m + 1) + 32'(r * 16), vecs[r].len);
      push_ar(vecs[r].first, 32'h1000_0000 * (vecs[r].first + 1) + 32'(r * 16), vecs[r].len);
      if (vecs[r].second >= 0)
        push_ar(vecs[r].second, 32'h1000_0000 * (vecs[r].second + 1) + 32'(r * 16), vecs[r].len);
      serve_ar(0);
      serve_r(vecs[r].first, int'(vecs[r].len), int'(vecs[r].len) + 1, 1'b0);
      if (vecs[r].second >= 0) begin
        serve_ar(0);
        serve_r(vecs[r].second, int'(vecs[r].len), int'(vecs[r].len) + 1, 1'b0);
      end
      chk("table_idle", busy, 0);
    end

    // Slave stalls the address phase for five cycles
    set_req(1, 32'h8000_0040, 8'd1);
    push_ar(1, 32'h8000_0040, 8'd1);
    serve_ar(5);
    serve_r(1, 1, 2, 1'b0);

    // rlast on the third beat of a four-beat burst
    set_req(0, 32'h0000_2000, 8'd3);
    push_ar(0, 32'h0000_2000, 8'd3);
    serve_ar(0);
    serve_r(0, 3, 3, 1'b0);
    tick();
    tick();
    #1;
    chk("len_err_sticky", len_err, 1);
    chk("len_err_idle", busy, 0);

    // Granted master aborts in ADDR
    set_req(0, 32'h0000_3000, 8'd0);
    tick();
    #1;
    chk("abort_addr_valid", s_arvalid, 1);
    m_arvalid[0] = 1'b0;
    #1;
    chk("abort_drop_valid", s_arvalid, 0);
    tick();
    s_rvalid = 1'b1;
    m_rready = 2'b11;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_stray_rvalid", m_rvalid, 0);
    chk("abort_stray_rready", s_rready, 0);
    s_rvalid = 1'b0;
    m_rready = 2'b00;

    // Reset during beat 1
    set_req(0, 32'h0000_4000, 8'd3);
    push_ar(0, 32'h0000_4000, 8'd3);
    serve_ar(0);
    s_rdata = 32'h1111_0000; s_rvalid = 1'b1; m_rready = 2'b11;
    tick();
    s_rdata = 32'h1111_0001;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    set_req(0, 32'h0000_5000, 8'd3);
    push_ar(0, 32'h0000_5000, 8'd3);
    serve_ar(0);
    serve_r(0, 3, 4, 1'b0);
    chk("ar_queue_drained", ar_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
